// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared stage codes, group indices and sequencer state encodings
//
// Purpose : common constants for the pipeline sequencer and its users.
//   STAGE_*      one-hot pipeline_stage codes presented to signal_generation_unit
//   GROUP_*      bit indices into the decoded opcode_group vector
//   seq_state_t  internal sequencer state encodings SEQ_S_IF..SEQ_S_WB
//   stage_of()   maps a sequencer state to the stage code it presents
package pipeline_sequencer_pkg;

  localparam logic [4:0] STAGE_IF  = 5'b00001;
  localparam logic [4:0] STAGE_ID  = 5'b00010;
  localparam logic [4:0] STAGE_EX  = 5'b00100;
  localparam logic [4:0] STAGE_MEM = 5'b01000;
  localparam logic [4:0] STAGE_WB  = 5'b10000;

  localparam int GROUP_ALU    = 0;
  localparam int GROUP_LOAD   = 1;
  localparam int GROUP_STORE  = 2;
  localparam int GROUP_BRANCH = 3;

  typedef enum logic [2:0] {
    SEQ_S_IF  = 3'd0,
    SEQ_S_ID  = 3'd1,
    SEQ_S_IF2 = 3'd2,
    SEQ_S_EX  = 3'd3,
    SEQ_S_MEM = 3'd4,
    SEQ_S_WB  = 3'd5
  } seq_state_t;

  // The second fetch cycle is still a fetch as far as downstream decode is
  // concerned; fetch_second distinguishes it.
  function automatic logic [4:0] stage_of(seq_state_t s);
    case (s)
      SEQ_S_IF:  return STAGE_IF;
      SEQ_S_ID:  return STAGE_ID;
      SEQ_S_IF2: return STAGE_IF;
      SEQ_S_EX:  return STAGE_EX;
      SEQ_S_MEM: return STAGE_MEM;
      SEQ_S_WB:  return STAGE_WB;
      default:   return STAGE_IF;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_sequencer_mem_wait_timer.sv
// rtl/pipeline_sequencer_mem_wait_timer.sv - data-memory wait-cycle counter with terminal flag
//
// Purpose : counts data-memory wait cycles while the sequencer sits in MEM.
// Ports   :
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   clear     in   synchronous clear (has priority over count_en)
//   count_en  in   increment this cycle
//   terminal  out  count has reached MAX_WAIT-1
module pipeline_sequencer_mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = (count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB control sequencer
//
// Purpose : steps each instruction through IF, ID, (IF2), EX, (MEM), WB,
//           stalling on memory wait states and aborting hung data accesses.
// Option  : SINGLE_STEP_EN adds step_mode/step_req and a step_pending register
//           that admits exactly one instruction per request.
// Ports   :
//   clk             in   system clock
//   reset           in   asynchronous active-low reset
//   enable          in   permits leaving IF for a new instruction
//   opcode_group    in   decoded group vector, valid from ID onward
//   two_word        in   instruction has a second program word (sampled in ID)
//   imem_ready      in   instruction word available this cycle
//   dmem_ready      in   data access completes this cycle
//   step_mode       in   (SINGLE_STEP_EN) single-step operation
//   step_req        in   (SINGLE_STEP_EN) request one instruction
//   pipeline_stage  out  registered one-hot stage code
//   fetch_second    out  registered, high during IF2
//   pc_inc          out  high in IF/IF2 while imem_ready
//   instr_done      out  high during WB
//   bus_error       out  registered pulse the cycle after a MEM timeout
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int STAGE_COUNT = 5,
  parameter int GROUP_COUNT = 8,
  parameter int MAX_WAIT    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [GROUP_COUNT-1:0] opcode_group,
  input  logic                   two_word,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
`ifdef SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step_req,
`endif
  output logic [STAGE_COUNT-1:0] pipeline_stage,
  output logic                   fetch_second,
  output logic                   pc_inc,
  output logic                   instr_done,
  output logic                   bus_error
);

  localparam logic [GROUP_COUNT-1:0] MEM_GROUPS =
    (GROUP_COUNT'(1) << GROUP_LOAD) | (GROUP_COUNT'(1) << GROUP_STORE);

  seq_state_t state;
  seq_state_t state_next;
  logic       step_ok;
  logic       wait_terminal;
  logic       mem_abort;
  logic       mem_op;

  assign mem_op = |(opcode_group & MEM_GROUPS);

  // Counter is held clear outside MEM, so it starts from zero on every entry.
  pipeline_sequencer_mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != SEQ_S_MEM),
    .count_en ((state == SEQ_S_MEM) && !dmem_ready),
    .terminal (wait_terminal)
  );

`ifdef SINGLE_STEP_EN
  logic step_pending;
  logic if_take;

  assign if_take = (state == SEQ_S_IF) && (state_next == SEQ_S_ID);
  assign step_ok = !step_mode || step_pending || step_req;

  // A request arriving on the admitting cycle is consumed by that instruction;
  // later requests during the instruction collapse into one pending step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_pending <= 1'b0;
    end else if (if_take) begin
      step_pending <= 1'b0;
    end else if (step_req) begin
      step_pending <= 1'b1;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  // State register; Moore outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= SEQ_S_IF;
      pipeline_stage <= STAGE_COUNT'(STAGE_IF);
      fetch_second   <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_next;
      pipeline_stage <= STAGE_COUNT'(stage_of(state_next));
      fetch_second   <= (state_next == SEQ_S_IF2);
      bus_error      <= mem_abort;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_S_IF:  if (enable && imem_ready && step_ok) state_next = SEQ_S_ID;
      SEQ_S_ID:  state_next = two_word ? SEQ_S_IF2 : SEQ_S_EX;
      SEQ_S_IF2: if (imem_ready) state_next = SEQ_S_EX;
      SEQ_S_EX:  state_next = mem_op ? SEQ_S_MEM : SEQ_S_WB;
      SEQ_S_MEM: begin
        // ready wins over a coincident timeout
        if (dmem_ready)         state_next = SEQ_S_WB;
        else if (wait_terminal) state_next = SEQ_S_IF;
      end
      SEQ_S_WB:  state_next = SEQ_S_IF;
      default:   state_next = SEQ_S_IF;
    endcase
  end

  // pc_inc is not qualified by enable; the PC unit pairs it with the stage move.
  always_comb begin
    pc_inc     = 1'b0;
    instr_done = 1'b0;
    mem_abort  = 1'b0;
    case (state)
      SEQ_S_IF:  pc_inc = imem_ready;
      SEQ_S_IF2: pc_inc = imem_ready;
      SEQ_S_MEM: mem_abort = !dmem_ready && wait_terminal;
      SEQ_S_WB:  instr_done = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - randomized self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

  localparam int MAXW = 16;
  localparam logic [4:0] P_IF  = 5'b00001;
  localparam logic [4:0] P_ID  = 5'b00010;
  localparam logic [4:0] P_EX  = 5'b00100;
  localparam logic [4:0] P_MEM = 5'b01000;
  localparam logic [4:0] P_WB  = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] opcode_group = 8'h00;
  logic       two_word = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic [4:0] pipeline_stage;
  logic       fetch_second;
  logic       pc_inc;
  logic       instr_done;
  logic       bus_error;
`ifdef SINGLE_STEP_EN
  logic       step_mode = 1'b0;
  logic       step_req = 1'b0;
  logic       step_req_nxt = 1'b0;
`endif

  int n_tests = 0;
  int n_fail = 0;
  bit berr_flag = 1'b0;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .STAGE_COUNT (5),
    .GROUP_COUNT (8),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .opcode_group   (opcode_group),
    .two_word       (two_word),
    .imem_ready     (imem_ready),
    .dmem_ready     (dmem_ready),
`ifdef SINGLE_STEP_EN
    .step_mode      (step_mode),
    .step_req       (step_req),
`endif
    .pipeline_stage (pipeline_stage),
    .fetch_second   (fetch_second),
    .pc_inc         (pc_inc),
    .instr_done     (instr_done),
    .bus_error      (bus_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rg();
    return 8'($urandom_range(0, 255));
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare
  // {stage, fetch_second, pc_inc, instr_done, bus_error} just before the rise.
  task automatic cyc(input logic rst, input logic en, input logic im, input logic dm,
                     input logic tw, input logic [7:0] grp, input logic [4:0] es,
                     input logic efs, input logic epc, input logic edone,
                     input logic eberr, input string tag);
    @(negedge clk);
    reset = rst;
    enable = en;
    imem_ready = im;
    dmem_ready = dm;
    two_word = tw;
    opcode_group = grp;
`ifdef SINGLE_STEP_EN
    step_req = step_req_nxt;
`endif
    #4;
    check_eq(tag, {23'd0, pipeline_stage, fetch_second, pc_inc, instr_done, bus_error},
                  {23'd0, es, efs, epc, edone, eberr});
  endtask

  // Reference model at instruction level: builds the expected cycle trace of
  // one instruction from its wait counts and decoded attributes.
  task automatic run_instr(input logic [7:0] grp, input bit tw, input int en_wait,
                           input int if_wait, input int if2_wait, input int d_wait,
                           input string tag);
    logic is_mem;
    logic eb;
    logic im;
    is_mem = grp[1] | grp[2];
    eb = berr_flag;
    berr_flag = 1'b0;
    for (int i = 0; i < en_wait; i++) begin
      im = rb();
      cyc(1, 0, im, rb(), rb(), rg(), P_IF, 0, im, 0, eb, {tag, "/if_noen"});
      eb = 1'b0;
    end
    for (int i = 0; i < if_wait; i++) begin
      cyc(1, rb(), 0, rb(), rb(), rg(), P_IF, 0, 0, 0, eb, {tag, "/if_wait"});
      eb = 1'b0;
    end
    cyc(1, 1, 1, rb(), rb(), rg(), P_IF, 0, 1, 0, eb, {tag, "/if"});
    cyc(1, rb(), rb(), rb(), tw, grp, P_ID, 0, 0, 0, 0, {tag, "/id"});
    if (tw) begin
      for (int i = 0; i < if2_wait; i++)
        cyc(1, rb(), 0, rb(), tw, grp, P_IF, 1, 0, 0, 0, {tag, "/if2_wait"});
      cyc(1, rb(), 1, rb(), tw, grp, P_IF, 1, 1, 0, 0, {tag, "/if2"});
    end
    cyc(1, rb(), rb(), rb(), tw, grp, P_EX, 0, 0, 0, 0, {tag, "/ex"});
    if (is_mem) begin
      if (d_wait >= MAXW) begin
        for (int i = 0; i < MAXW; i++)
          cyc(1, rb(), rb(), 0, tw, grp, P_MEM, 0, 0, 0, 0, {tag, "/mem_hang"});
        berr_flag = 1'b1;
        return;
      end
      for (int i = 0; i < d_wait; i++)
        cyc(1, rb(), rb(), 0, tw, grp, P_MEM, 0, 0, 0, 0, {tag, "/mem_wait"});
      cyc(1, rb(), rb(), 1, tw, grp, P_MEM, 0, 0, 0, 0, {tag, "/mem"});
    end
    cyc(1, rb(), rb(), rb(), tw, grp, P_WB, 0, 0, 1, 0, {tag, "/wb"});
  endtask

  initial begin
    logic [7:0] grp;
    int sel;

    // reset state, with imem_ready high so pc_inc follows it from IF
    cyc(0, 1, 1, 0, 0, 8'h00, P_IF, 0, 1, 0, 0, "reset0");
    cyc(0, 1, 0, 1, 1, 8'hff, P_IF, 0, 0, 0, 0, "reset1");

    run_instr(8'h01, 0, 0, 0, 0, 0, "alu");
    run_instr(8'h04, 1, 0, 0, 2, 0, "sts_if2_wait");
    run_instr(8'h02, 0, 0, 0, 0, MAXW, "ld_timeout");
    run_instr(8'h02, 0, 0, 0, 0, MAXW - 1, "ld_ready_last");
    run_instr(8'h06, 1, 2, 1, 0, 3, "lds_waits");

    // reset in the middle of MEM abandons the access
    cyc(1, 1, 1, 0, 0, 8'h00, P_IF, 0, 1, 0, 0, "mr/if");
    cyc(1, 0, 0, 0, 0, 8'h02, P_ID, 0, 0, 0, 0, "mr/id");
    cyc(1, 0, 0, 0, 0, 8'h02, P_EX, 0, 0, 0, 0, "mr/ex");
    cyc(1, 0, 0, 0, 0, 8'h02, P_MEM, 0, 0, 0, 0, "mr/mem");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 1, 0, 8'h02, P_IF, 0, 1, 0, 0, "mr/reset");
    berr_flag = 1'b0;
    run_instr(8'h01, 0, 0, 0, 0, 0, "post_reset");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       grp = 8'h01;
        1:       grp = 8'h02;
        2:       grp = 8'h04;
        default: grp = rg();
      endcase
      run_instr(grp, bit'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, MAXW + 1), "rand");
    end

    cyc(1, 0, 0, 0, 0, 8'h00, P_IF, 0, 0, 0, berr_flag, "idle_end");
    berr_flag = 1'b0;

`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(1, 1, 1, rb(), 0, 8'h01, P_IF, 0, 1, 0, 0, "step/hold");
    step_req_nxt = 1'b1;
    cyc(1, 1, 1, 0, 0, 8'h01, P_IF, 0, 1, 0, 0, "step/if");
    step_req_nxt = 1'b0;
    cyc(1, 1, 1, 0, 0, 8'h01, P_ID, 0, 0, 0, 0, "step/id");
    cyc(1, 1, 1, 0, 0, 8'h01, P_EX, 0, 0, 0, 0, "step/ex");
    cyc(1, 1, 1, 0, 0, 8'h01, P_WB, 0, 0, 1, 0, "step/wb");
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 1, 0, 0, 8'h01, P_IF, 0, 1, 0, 0, "step/hold_after");
    step_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
